i2s_receiver: RTL and testbench

// - I2S slave receiver: the capture-side counterpart of the DAC-side I2S transmitter.
// - Takes codec ADC serial data plus externally supplied BCLK and LRCLK, all sampled in clk_125.
// - Deserialises left and right slots.
// - Presents each stereo frame as a line_in_l/line_in_r pair with a 1-cycle valid pulse,
//   for the DSP/AXIS path.

---
 rtl/i2s_receiver.sv | 140 ++++++++++++++
 tb/tb_i2s_receiver.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// I2S slave receiver: synchronises externally clocked BCLK/LRCLK/SDATA into clk_125
// and deserialises each left/right slot pair into one stereo sample with a valid pulse.
module i2s_receiver #(
  parameter int DATA_WIDTH  = 32,
  parameter int AUDIO_WIDTH = 24
) (
  input  logic                   clk_125,
  input  logic                   S_AXIS_ARESETN,
  input  logic                   ctrl_sw,
  input  logic                   bclk,
  input  logic                   lrclk,
  input  logic                   serial_data_in1,
  input  logic                   serial_data_in2,
  output logic [AUDIO_WIDTH-1:0] line_in_l,
  output logic [AUDIO_WIDTH-1:0] line_in_r,
  output logic                   line_in_valid,
  output logic                   next_adc_sample,
  output logic                   slot_err
);

  localparam int CW = $clog2(2 * DATA_WIDTH);
  localparam logic [CW-1:0] CNT_MAX   = CW'(2 * DATA_WIDTH - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  logic [1:0]             rst_pipe;
  logic                   rst_n;
  logic                   sd_raw;
  logic [1:0]             bclk_sync, lr_sync, sd_sync;
  logic                   bclk_prev;
  logic                   rise, lr_q, sd_q;
  logic                   lr_last;
  logic                   lr_edge;
  logic                   len_bad;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [AUDIO_WIDTH-1:0] shreg, shreg_next;
  logic [AUDIO_WIDTH-1:0] left_hold, right_hold;
  logic                   frame_done;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk_125 or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) rst_pipe <= 2'b00;
    else                 rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  assign sd_raw = ctrl_sw ? serial_data_in1 : serial_data_in2;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      bclk_prev <= 1'b0;
      rise      <= 1'b0;
      lr_q      <= 1'b0;
      sd_q      <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk};
      lr_sync   <= {lr_sync[0], lrclk};
      sd_sync   <= {sd_sync[0], sd_raw};
      bclk_prev <= bclk_sync[1];
      rise      <= bclk_sync[1] & ~bclk_prev;
      lr_q      <= lr_sync[1];
      sd_q      <= sd_sync[1];
    end
  end

  // NOTE: default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    shreg_next = shreg;
    for (int i = 0; i < AUDIO_WIDTH; i++) begin
      if (cnt == CW'(AUDIO_WIDTH - 1 - i)) shreg_next[i] = sd_q;
    end
  end

  assign lr_edge = (lr_q != lr_last);
  assign len_bad = (cnt != SLOT_LAST);

  // The bit sampled on the edge rise is the old slot's LSB, so commits use shreg_next.
  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SYNC;
      cnt        <= '0;
      shreg      <= '0;
      left_hold  <= '0;
      right_hold <= '0;
      lr_last    <= 1'b0;
      frame_done <= 1'b0;
      slot_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (rise) begin
        lr_last <= lr_q;
        if (lr_edge) begin
          cnt   <= '0;
          shreg <= '0;
          case (state)
            SYNC: if (!lr_q) state <= LEFT;
            LEFT: begin
              left_hold <= shreg_next;
              state     <= RIGHT;
              if (len_bad) slot_err <= 1'b1;
            end
            RIGHT: begin
              right_hold <= shreg_next;
              frame_done <= 1'b1;
              state      <= LEFT;
              if (len_bad) slot_err <= 1'b1;
            end
            default: state <= SYNC;
          endcase
        end else begin
          shreg <= shreg_next;
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      line_in_l       <= '0;
      line_in_r       <= '0;
      line_in_valid   <= 1'b0;
      next_adc_sample <= 1'b0;
    end else begin
      line_in_valid   <= frame_done;
      next_adc_sample <= frame_done;
      if (frame_done) begin
        line_in_l <= left_hold;
        line_in_r <= right_hold;
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Randomised bench for i2s_receiver: a slot-level stream builder predicts frames,
// a monitor pops the scoreboard on each valid pulse and checks data and latency.
module tb_i2s_receiver;

  localparam int DW   = 32;
  localparam int AW   = 24;
  localparam int HALF = 8;
  localparam int LAT  = 4;

  logic          clk_125 = 1'b0;
  logic          S_AXIS_ARESETN = 1'b0;
  logic          ctrl_sw = 1'b1;
  logic          bclk = 1'b0;
  logic          lrclk = 1'b0;
  logic          serial_data_in1 = 1'b0;
  logic          serial_data_in2 = 1'b0;
  logic [AW-1:0] line_in_l, line_in_r;
  logic          line_in_valid, next_adc_sample, slot_err;

  i2s_receiver #(.DATA_WIDTH(DW), .AUDIO_WIDTH(AW)) dut (
    .clk_125(clk_125),
    .S_AXIS_ARESETN(S_AXIS_ARESETN),
    .ctrl_sw(ctrl_sw),
    .bclk(bclk),
    .lrclk(lrclk),
    .serial_data_in1(serial_data_in1),
    .serial_data_in2(serial_data_in2),
    .line_in_l(line_in_l),
    .line_in_r(line_in_r),
    .line_in_valid(line_in_valid),
    .next_adc_sample(next_adc_sample),
    .slot_err(slot_err)
  );

  always #4 clk_125 = ~clk_125;

  typedef struct {
    logic          lr;
    logic          sd;
    bit            commit;
    logic [AW-1:0] l;
    logic [AW-1:0] r;
  } txbit_t;

  typedef struct {
    logic [AW-1:0] l;
    logic [AW-1:0] r;
    int            cyc;
  } exp_t;

  txbit_t        tx[$];
  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            valid_cnt = 0;
  int            nas_cnt = 0;
  int            route = 1;
  int            phase;       // 0 unsynced, 1 inside left slot, 2 inside right slot
  bit            seen_high;
  int            prev_n;
  bit            exp_err;
  logic [AW-1:0] exp_l, exp_r;

  always @(posedge clk_125) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample kept from an n-bit MSB-first slot: top AW bits, zero-padded when short.
  function automatic logic [AW-1:0] model_sample(input logic [63:0] v, input int n, input bit match);
    logic [63:0] m;
    if (!match) return '0;
    m = v & ((64'd1 << n) - 64'd1);
    if (n >= AW) return AW'(m >> (n - AW));
    return AW'(m << (AW - n));
  endfunction

  function automatic logic [63:0] word(input logic [AW-1:0] s);
    logic [7:0] pad;
    pad = 8'($urandom);
    return {32'd0, s, pad};
  endfunction

  task automatic begin_stream();
    tx.delete();
    phase     = 0;
    seen_high = 1'b0;
    prev_n    = 0;
  endtask

  task automatic add_slot(input logic lr, input logic [63:0] v, input int n);
    txbit_t        b;
    logic [AW-1:0] s;
    s = model_sample(v, n, (ctrl_sw == 1'b1) == (route == 1));
    if (lr == 1'b0) begin
      if (phase == 2) begin
        b = tx.pop_back();
        b.commit = 1'b1;
        b.l = exp_l;
        b.r = exp_r;
        tx.push_back(b);
        if (prev_n != DW) exp_err = 1'b1;
      end
      if (phase == 2 || (phase == 0 && seen_high)) phase = 1;
      exp_l = s;
    end else begin
      if (phase == 1) begin
        if (prev_n != DW) exp_err = 1'b1;
        phase = 2;
      end else if (phase == 0 && n >= 2) begin
        seen_high = 1'b1;
      end
      exp_r = s;
    end
    for (int i = 0; i < n; i++) begin
      b.lr = lr;
      b.sd = v[n-1-i];
      b.commit = 1'b0;
      b.l = '0;
      b.r = '0;
      tx.push_back(b);
    end
    prev_n = n;
  endtask

  task automatic add_frame(input logic [63:0] l, input logic [63:0] r);
    add_slot(1'b0, l, DW);
    add_slot(1'b1, r, DW);
  endtask

  // Word select leads data by one bit period, as on a real I2S link.
  task automatic send();
    exp_t e;
    for (int i = 0; i < tx.size(); i++) begin
      @(negedge clk_125);
      bclk = 1'b0;
      lrclk = (i + 1 < tx.size()) ? tx[i+1].lr : tx[i].lr;
      serial_data_in1 = (route == 1) ? tx[i].sd : 1'b0;
      serial_data_in2 = (route == 2) ? tx[i].sd : 1'b0;
      repeat (HALF) @(negedge clk_125);
      bclk = 1'b1;
      if (tx[i].commit) begin
        e.l = tx[i].l;
        e.r = tx[i].r;
        e.cyc = cyc + 1 + LAT;
        sb.push_back(e);
      end
      repeat (HALF - 1) @(negedge clk_125);
    end
    @(negedge clk_125);
    bclk = 1'b0;
    tx.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk_125);
      n++;
    end
    repeat (20) @(negedge clk_125);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic end_checks(input int frames);
    check("valid_count", valid_cnt, frames);
    check("next_adc_sample_count", nas_cnt, frames);
    check("slot_err", slot_err, exp_err);
  endtask

  task automatic do_reset(input logic lr_level);
    @(negedge clk_125);
    S_AXIS_ARESETN = 1'b0;
    bclk = 1'b0;
    lrclk = lr_level;
    serial_data_in1 = 1'b0;
    serial_data_in2 = 1'b0;
    #1;
    check("rst_line_in_l", line_in_l, 0);
    check("rst_line_in_r", line_in_r, 0);
    check("rst_valid", line_in_valid, 0);
    check("rst_next_adc_sample", next_adc_sample, 0);
    check("rst_slot_err", slot_err, 0);
    repeat (3) @(negedge clk_125);
    S_AXIS_ARESETN = 1'b1;
    repeat (4) @(negedge clk_125);
    exp_err = 1'b0;
    valid_cnt = 0;
    nas_cnt = 0;
    sb.delete();
    begin_stream();
  endtask

  always @(negedge clk_125) begin : monitor
    exp_t e;
    if (S_AXIS_ARESETN) begin
      if (line_in_valid) valid_cnt++;
      if (next_adc_sample) nas_cnt++;
      if (line_in_valid || next_adc_sample)
        check("next_adc_sample_with_valid", next_adc_sample, line_in_valid);
      if (line_in_valid) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got pulse at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("line_in_l", line_in_l, e.l);
          check("line_in_r", line_in_r, e.r);
          check("valid_latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] base;

    // Basic frame with known values.
    do_reset(1'b0);
    add_slot(1'b1, 64'd0, 4);
    add_frame(64'hABCDEF00, 64'h12345600);
    add_slot(1'b0, 64'd0, 4);
    send();
    drain();
    end_checks(1);
    check("hold_l", line_in_l, 24'hABCDEF);
    check("hold_r", line_in_r, 24'h123456);

    // Reset released mid right slot with lrclk high: partial slot is dropped.
    do_reset(1'b1);
    add_slot(1'b1, 64'($urandom), 12);
    add_frame(word(AW'($urandom)), word(AW'($urandom)));
    add_slot(1'b0, 64'd0, 4);
    send();
    drain();
    end_checks(1);

    // Ten consecutive frames of incrementing samples.
    do_reset(1'b0);
    base = AW'($urandom);
    add_slot(1'b1, 64'd0, 4);
    for (int k = 0; k < 10; k++)
      add_frame(word(base + AW'(2 * k)), word(base + AW'(2 * k + 1)));
    add_slot(1'b0, 64'd0, 4);
    send();
    drain();
    end_checks(10);

    // Short 20-bit left slot: zero-padded LSBs and sticky slot_err.
    do_reset(1'b0);
    add_slot(1'b1, 64'd0, 4);
    add_slot(1'b0, 64'hFFFFF, 20);
    add_slot(1'b1, word(AW'($urandom)), DW);
    add_frame(word(AW'($urandom)), word(AW'($urandom)));
    add_slot(1'b0, 64'd0, 4);
    send();
    drain();
    end_checks(2);

    // Data only on path 2: captured with ctrl_sw=0, zeros with ctrl_sw=1.
    do_reset(1'b0);
    ctrl_sw = 1'b0;
    route = 2;
    add_slot(1'b1, 64'd0, 4);
    add_frame(word(AW'($urandom)), word(AW'($urandom)));
    add_slot(1'b0, 64'd0, 4);
    send();
    drain();
    end_checks(1);

    do_reset(1'b0);
    ctrl_sw = 1'b1;
    add_slot(1'b1, 64'd0, 4);
    add_frame(word(AW'($urandom) | 24'h800001), word(AW'($urandom) | 24'h800001));
    add_slot(1'b0, 64'd0, 4);
    send();
    drain();
    end_checks(1);
    route = 1;

    // Reset during a left slot, then normal capture after the next falling edge.
    do_reset(1'b0);
    add_slot(1'b1, 64'd0, 4);
    add_frame(word(AW'($urandom) | 24'h000100), word(AW'($urandom)));
    add_slot(1'b0, word(AW'($urandom)), 10);
    send();
    drain();
    end_checks(1);
    do_reset(1'b0);
    add_slot(1'b1, 64'd0, 4);
    add_frame(word(AW'($urandom)), word(AW'($urandom)));
    add_slot(1'b0, 64'd0, 4);
    send();
    drain();
    end_checks(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
